// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        HALT
    } fetch_state_e;

    // Bytes per fetched instruction; the sequential PC step.
    localparam int unsigned INSTR_BYTES = 4;

    // Wide enough for FLUSH_DEPTH up to 15.
    localparam int unsigned FLUSH_CNT_W = 4;

    // JALR semantics: the architectural target always has bit 0 cleared.
    function automatic logic [63:0] jalr_clear(input logic [63:0] target);
        return {target[63:1], 1'b0};
    endfunction

endpackage

// File: rtl/redirect_flush_timer.sv
// Loadable down-counter timing the squash window after a redirect.
module redirect_flush_timer
    import fetch_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic tick,
    output logic active,
    output logic last
);

    localparam logic [FLUSH_CNT_W-1:0] DEPTH_V = FLUSH_CNT_W'(FLUSH_DEPTH);

    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic [FLUSH_CNT_W-1:0] cnt_d;

    // Next count: clear beats load beats decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = DEPTH_V;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);
    assign last   = (cnt_q == {{(FLUSH_CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Architectural fetch PC: sequential advance, execute redirects, flush window, misalign halt.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_load,
    input  logic [63:0]      entry_pc,
    input  logic             ex_valid,
    input  logic             ex_jump,
    input  logic [63:0]      ex_target,
    input  logic             if_ready,
    output logic [63:0]      pc_out,
    output logic             pc_valid,
    output logic             flush_out,
    output logic             misalign_out,
    output logic [63:0]      misalign_addr,
    output logic [CNT_W-1:0] redirect_count
);

    fetch_state_e     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic [63:0]      misalign_addr_q, misalign_addr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             redirect;
    logic [63:0]      eff_target;
    logic             timer_load;
    logic             timer_clear;
    logic             timer_tick;
    logic             timer_active;
    logic             timer_last;

    redirect_flush_timer #(
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_flush_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .clear  (timer_clear),
        .tick   (timer_tick),
        .active (timer_active),
        .last   (timer_last)
    );

    // Redirects only matter while fetch is live; IDLE/HALT ignore execute.
    assign redirect   = ex_valid && ex_jump && ((state_q == RUN) || (state_q == FLUSH));
    assign eff_target = jalr_clear(ex_target);

    // Next state / next PC, priority entry_load > redirect > sequential advance.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        flush_d         = flush_q;
        misalign_d      = misalign_q;
        misalign_addr_d = misalign_addr_q;
        count_d         = count_q;
        timer_load      = 1'b0;
        timer_clear     = 1'b0;
        timer_tick      = 1'b0;

        if (entry_load) begin
            pc_d        = entry_pc;
            state_d     = RUN;
            flush_d     = 1'b0;
            misalign_d  = 1'b0;
            timer_clear = 1'b1;
        end else if (redirect) begin
            if (eff_target[1]) begin
                // Misaligned: keep the old PC, park in HALT, squash younger work once.
                state_d         = HALT;
                misalign_d      = 1'b1;
                misalign_addr_d = eff_target;
                flush_d         = 1'b1;
                timer_clear     = 1'b1;
            end else begin
                // Also wins over a same-cycle fetch handshake; flush covers that fetch.
                pc_d       = eff_target;
                state_d    = FLUSH;
                flush_d    = 1'b1;
                timer_load = 1'b1;
                count_d    = count_q + CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (if_ready) begin
                        pc_d = pc_q + 64'(INSTR_BYTES);
                    end
                end
                FLUSH: begin
                    timer_tick = 1'b1;
                    if (timer_last || !timer_active) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                    end
                end
                HALT: begin
                    flush_d = 1'b0;
                end
                IDLE: begin
                    flush_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Architectural state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            flush_q         <= flush_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            count_q         <= count_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid       = (state_q == RUN);
    assign flush_out      = flush_q;
    assign misalign_out   = misalign_q;
    assign misalign_addr  = misalign_addr_q;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with a cycle scoreboard fed by a behavioural model.
module tb_fetch_pc_sequencer;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          FD       = 2;
    localparam int          CW       = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          entry_load;
    logic [63:0]   entry_pc;
    logic          ex_valid;
    logic          ex_jump;
    logic [63:0]   ex_target;
    logic          if_ready;
    logic [63:0]   pc_out;
    logic          pc_valid;
    logic          flush_out;
    logic          misalign_out;
    logic [63:0]   misalign_addr;
    logic [CW-1:0] redirect_count;

    fetch_pc_sequencer #(
        .RESET_PC    (RESET_PC),
        .FLUSH_DEPTH (FD),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry_load     (entry_load),
        .entry_pc       (entry_pc),
        .ex_valid       (ex_valid),
        .ex_jump        (ex_jump),
        .ex_target      (ex_target),
        .if_ready       (if_ready),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .flush_out      (flush_out),
        .misalign_out   (misalign_out),
        .misalign_addr  (misalign_addr),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]   pc;
        logic          valid;
        logic          flush;
        logic          mis;
        logic [63:0]   addr;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int            m_state;
    logic [63:0]   m_pc;
    logic          m_flush;
    logic          m_mis;
    logic [63:0]   m_addr;
    logic [CW-1:0] m_cnt;
    int            m_rem;

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = RESET_PC;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        m_addr  = 64'h0;
        m_cnt   = '0;
        m_rem   = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [63:0] t;
        t = ex_target & ~64'h1;
        if (entry_load) begin
            m_pc    = entry_pc;
            m_state = M_RUN;
            m_flush = 1'b0;
            m_mis   = 1'b0;
            m_rem   = 0;
        end else if (ex_valid && ex_jump && (m_state == M_RUN || m_state == M_FLUSH)) begin
            if (t[1]) begin
                m_state = M_HALT;
                m_mis   = 1'b1;
                m_addr  = t;
                m_flush = 1'b1;
                m_rem   = 0;
            end else begin
                m_pc    = t;
                m_state = M_FLUSH;
                m_flush = 1'b1;
                m_rem   = FD;
                m_cnt   = m_cnt + 1;
            end
        end else if (m_state == M_RUN) begin
            if (if_ready) m_pc = m_pc + 64'd4;
        end else if (m_state == M_FLUSH) begin
            if (m_rem <= 1) begin
                m_state = M_RUN;
                m_flush = 1'b0;
                m_rem   = 0;
            end else begin
                m_rem = m_rem - 1;
            end
        end else begin
            m_flush = 1'b0;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.pc    = m_pc;
        o.valid = (m_state == M_RUN);
        o.flush = m_flush;
        o.mis   = m_mis;
        o.addr  = m_addr;
        o.cnt   = m_cnt;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.pc    = pc_out;
        o.valid = pc_valid;
        o.flush = flush_out;
        o.mis   = misalign_out;
        o.addr  = misalign_addr;
        o.cnt   = redirect_count;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        assert (got === expv)
        else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One clock: model predicts, scoreboard holds the prediction, DUT is compared after the edge.
    task automatic tick(input string tag);
        obs_t e;
        obs_t o;
        model_step();
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        o = dut_obs();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            assert (o === e)
            else begin
                n_err++;
                $error("FAIL %s: got pc=%h v=%b f=%b m=%b a=%h c=%0d expected pc=%h v=%b f=%b m=%b a=%h c=%0d",
                       tag, o.pc, o.valid, o.flush, o.mis, o.addr, o.cnt,
                       e.pc, e.valid, e.flush, e.mis, e.addr, e.cnt);
            end
        end
    endtask

    task automatic clear_ex();
        ex_valid  = 1'b0;
        ex_jump   = 1'b0;
        ex_target = 64'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    pc_out,               RESET_PC);
        check({tag, "_valid"}, {63'h0, pc_valid},     64'h0);
        check({tag, "_flush"}, {63'h0, flush_out},    64'h0);
        check({tag, "_mis"},   {63'h0, misalign_out}, 64'h0);
        check({tag, "_addr"},  misalign_addr,         64'h0);
        check({tag, "_cnt"},   64'(redirect_count),   64'h0);
    endtask

    initial begin
        reset      = 1'b0;
        entry_load = 1'b0;
        entry_pc   = 64'h0;
        if_ready   = 1'b0;
        clear_ex();
        model_reset();
        #3;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: entry load and sequential advance
        tick("idle_hold");
        check("idle_pc", pc_out, RESET_PC);
        entry_load = 1'b1;
        entry_pc   = 64'h1000;
        if_ready   = 1'b1;
        tick("entry");
        entry_load = 1'b0;
        check("entry_pc", pc_out, 64'h1000);
        tick("seq1");
        tick("seq2");
        tick("seq3");
        check("seq_pc", pc_out, 64'h100C);

        // 2: redirect coincident with handshake, 2-cycle flush
        entry_load = 1'b1;
        entry_pc   = 64'h2000;
        tick("entry2");
        entry_load = 1'b0;
        ex_valid   = 1'b1;
        ex_jump    = 1'b1;
        ex_target  = 64'h3000;
        tick("redir");
        clear_ex();
        check("redir_pc", pc_out, 64'h3000);
        check("redir_flush", {63'h0, flush_out}, 64'h1);
        check("redir_cnt", 64'(redirect_count), 64'h1);
        tick("flush2");
        check("flush2_valid", {63'h0, pc_valid}, 64'h0);
        tick("resume");
        check("resume_valid", {63'h0, pc_valid}, 64'h1);
        if_ready = 1'b0;
        ex_valid = 1'b1;
        tick("valid_nojump");
        clear_ex();
        ex_jump   = 1'b1;
        ex_target = 64'h7777_0000;
        tick("jump_novalid");
        clear_ex();
        check("nojump_pc", pc_out, 64'h3000);

        // 3: bit-0 clear, then misaligned target halts
        ex_valid  = 1'b1;
        ex_jump   = 1'b1;
        ex_target = 64'h4001;
        tick("bit0");
        clear_ex();
        check("bit0_pc", pc_out, 64'h4000);
        tick("bit0_f");
        tick("bit0_run");
        ex_valid  = 1'b1;
        ex_jump   = 1'b1;
        ex_target = 64'h4002;
        tick("misalign");
        check("mis_flag", {63'h0, misalign_out}, 64'h1);
        check("mis_addr", misalign_addr, 64'h4002);
        ex_target = 64'h8000;
        tick("halt1");
        tick("halt2");
        clear_ex();
        check("halt_pc", pc_out, 64'h4000);
        check("halt_valid", {63'h0, pc_valid}, 64'h0);

        // 4: redirect during first flush cycle restarts the window; stall holds pc
        entry_load = 1'b1;
        entry_pc   = 64'h4800;
        tick("entry4");
        entry_load = 1'b0;
        ex_valid   = 1'b1;
        ex_jump    = 1'b1;
        ex_target  = 64'h6000;
        tick("redir_a");
        ex_target = 64'h5000;
        tick("redir_b");
        clear_ex();
        check("redir_b_pc", pc_out, 64'h5000);
        check("redir_b_cnt", 64'(redirect_count), 64'h4);
        tick("ext_f");
        check("ext_flush", {63'h0, flush_out}, 64'h1);
        tick("ext_run");
        check("ext_done", {63'h0, flush_out}, 64'h0);
        tick("stall1");
        tick("stall2");
        check("stall_pc", pc_out, 64'h5000);

        // 5: PC wrap, async reset mid-flush, entry_load beats redirect
        entry_load = 1'b1;
        entry_pc   = 64'hFFFF_FFFF_FFFF_FFFC;
        if_ready   = 1'b1;
        tick("entry_top");
        entry_load = 1'b0;
        tick("wrap");
        check("wrap_pc", pc_out, 64'h0);
        ex_valid  = 1'b1;
        ex_jump   = 1'b1;
        ex_target = 64'h7000;
        tick("pre_reset");
        clear_ex();
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        entry_load = 1'b1;
        entry_pc   = 64'h8000;
        tick("entry5");
        entry_pc  = 64'h9000;
        ex_valid  = 1'b1;
        ex_jump   = 1'b1;
        ex_target = 64'hA000;
        tick("entry_vs_redir");
        entry_load = 1'b0;
        clear_ex();
        check("prio_pc", pc_out, 64'h9000);
        check("prio_flush", {63'h0, flush_out}, 64'h0);
        tick("after_prio");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
